voice_alloc: RTL and testbench
==============================

// Module: voice_alloc
// PURPOSE
//   Polyphonic voice allocator feeding the 4-voice NCO bank. Consumes decoded
//   note-on/note-off events from the MIDI parser and drives NOTE_NUM_0..3 /
//   NOTE_VEL_0..3 of the NCO bank. Free voices are used first; when all four
//   are busy the oldest voice is stolen. Sits directly upstream of nco_bank.
// PARAMETERS
//   STEAL   1  1: steal oldest voice when all busy; 0: drop note-on when full
// PORTS
//   CLK         in   1  system clock (100 MHz)
//   RST         in   1  reset, asynchronous, active-high
//   CE          in   1  clock enable; all state advances only when CE=1
//   EVT_VALID   in   1  event valid (MIDI parser)
//   EVT_RDY     out  1  allocator ready; event accepted on edge with VALID&RDY&CE
//   EVT_ON      in   1  1 = note-on, 0 = note-off
//   EVT_NOTE    in   7  MIDI note number
//   EVT_VEL     in   7  MIDI velocity (note-on with VEL=0 is treated as note-off)
//   ALL_OFF     in   1  synchronous: zero all velocities and mark all voices free
//   NOTE_NUM_n  out  7  n=0..3, note number of voice n (to nco_bank)
//   NOTE_VEL_n  out  7  n=0..3, velocity of voice n; 0 = silent
//   ACTIVE      out  4  bit n = voice n holds a sounding note
// BEHAVIOUR
//   Reset: NOTE_NUM_n=0, NOTE_VEL_n=0, ACTIVE=0, rank[n]=n, EVT_RDY=1, state IDLE.
//   Per voice: note[6:0], vel[6:0], active, rank[1:0] (0=newest, 3=oldest).
//   The ranks always form a permutation of 0..3.
//   FSM (advances only on CE=1):
//     IDLE   EVT_RDY=1. On accept: latch ON/NOTE/VEL into event register.
//            EVT_ON=1 with VEL=0 is latched as off. Next state: SCAN, idx=0.
//     SCAN   EVT_RDY=0; one voice per cycle, idx 0..3 (4 cycles). Records:
//            match = first idx with active & note==EVT_NOTE;
//            free  = first idx with !active; oldest = idx with rank==3.
//            After idx=3: COMMIT.
//     COMMIT One cycle, EVT_RDY=0. Writes the outputs, then returns to IDLE.
//   Target selection in COMMIT:
//     note-on: match ? match : free ? free : (STEAL ? oldest : none).
//       On target v: note=EVT_NOTE, vel=EVT_VEL, active=1. Ranks: voices with
//       rank<rank[v] increment; rank[v]=0. With none, nothing changes.
//     note-off: match found -> vel=0, active=0, note unchanged (keeps NCO
//       pitch stable), ranks unchanged. No match -> no change.
//   Latency: accept on edge E0; SCAN on E1..E4; outputs update on E5;
//     EVT_RDY=1 again after E5. Throughput: 1 event per 6 CE cycles.
//   Outputs are registered and change only in COMMIT or on ALL_OFF/RST.
//   ALL_OFF: priority over the FSM. vel=0, active=0 for all voices; note and
//     rank retained; FSM forced to IDLE; any in-flight event is discarded.
//   CE=0: FSM frozen, EVT_RDY holds its value, no accept.
//   RST mid-SCAN/COMMIT: immediate return to reset values; event lost.
//   Duplicate note-on (retrigger) reuses the matching voice and never takes a
//     second voice.
// TESTING
//   1 Reset, on(60,100) -> after 6 cycles NOTE_NUM_0=60, NOTE_VEL_0=100, ACTIVE=0001.
//   2 on 60,62,64,65 then on 67 (STEAL=1) -> voice 0 (oldest) becomes 67/vel;
//     ACTIVE=1111; with STEAL=0 the outputs are unchanged.
//   3 on(60,100), on(60,50) -> voice 0 vel=50, ACTIVE=0001 (no second voice).
//   4 on(60,100), off(60) -> NOTE_NUM_0=60, NOTE_VEL_0=0, ACTIVE=0000;
//     on(60,vel 0) gives the same result; off(61) -> no change.
//   5 EVT_VALID held during SCAN -> EVT_RDY=0 for 5 cycles and the second event
//     is accepted only at the next IDLE; toggle CE -> latency stretches by
//     the number of CE=0 cycles.
//   6 ALL_OFF or RST asserted mid-SCAN -> all vel=0, EVT_RDY=1 on the next cycle,
//     and the pending event has no effect.

Source files
------------

// File: rtl/voice_alloc_if.sv
// Event handshake between the MIDI parser (master) and the voice allocator (slave).
interface voice_alloc_if;
  logic       evt_valid;
  logic       evt_rdy;
  logic       evt_on;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;

  modport master (output evt_valid, output evt_on, output evt_note, output evt_vel,
                  input evt_rdy);
  modport slave  (input evt_valid, input evt_on, input evt_note, input evt_vel,
                  output evt_rdy);
endinterface

// File: rtl/voice_alloc.sv
// Four-voice polyphonic allocator: free voices first, then steal the oldest (rank 3).
// Each event is scanned one voice per cycle, then committed in a single cycle.
module voice_alloc #(
  parameter bit STEAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          all_off,
  voice_alloc_if.slave  evt,
  output logic [6:0]    note_num_0,
  output logic [6:0]    note_num_1,
  output logic [6:0]    note_num_2,
  output logic [6:0]    note_num_3,
  output logic [6:0]    note_vel_0,
  output logic [6:0]    note_vel_1,
  output logic [6:0]    note_vel_2,
  output logic [6:0]    note_vel_3,
  output logic [3:0]    active
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0] state;
  logic [1:0] idx;

  logic       ev_on;
  logic [6:0] ev_note;
  logic [6:0] ev_vel;

  logic       match_found;
  logic [1:0] match_idx;
  logic       free_found;
  logic [1:0] free_idx;
  logic [1:0] oldest_idx;

  logic [6:0] note [4];
  logic [6:0] vel  [4];
  logic [1:0] rank [4];
  logic [3:0] act;

  logic       tgt_valid;
  logic [1:0] tgt_idx;

  assign evt.evt_rdy = (state == IDLE);

  // Retrigger beats free voice, free voice beats stealing.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_idx   = 2'd0;
    if (match_found) begin
      tgt_valid = 1'b1;
      tgt_idx   = match_idx;
    end else if (free_found) begin
      tgt_valid = 1'b1;
      tgt_idx   = free_idx;
    end else if (STEAL) begin
      tgt_valid = 1'b1;
      tgt_idx   = oldest_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      ev_on       <= 1'b0;
      ev_note     <= 7'd0;
      ev_vel      <= 7'd0;
      match_found <= 1'b0;
      match_idx   <= 2'd0;
      free_found  <= 1'b0;
      free_idx    <= 2'd0;
      oldest_idx  <= 2'd0;
      act         <= 4'd0;
      for (int v = 0; v < 4; v++) begin
        note[v] <= 7'd0;
        vel[v]  <= 7'd0;
        rank[v] <= 2'(v);
      end
    end else if (ce) begin
      if (all_off) begin
        state <= IDLE;
        act   <= 4'd0;
        for (int v = 0; v < 4; v++) begin
          vel[v] <= 7'd0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (evt.evt_valid) begin
              // A note-on with zero velocity is a note-off in MIDI.
              ev_on       <= evt.evt_on && (evt.evt_vel != 7'd0);
              ev_note     <= evt.evt_note;
              ev_vel      <= evt.evt_vel;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              idx         <= 2'd0;
              state       <= SCAN;
            end
          end
          SCAN: begin
            if (act[idx] && (note[idx] == ev_note) && !match_found) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            if (!act[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            if (rank[idx] == 2'd3) begin
              oldest_idx <= idx;
            end
            if (idx == 2'd3) begin
              state <= COMMIT;
            end
            idx <= idx + 2'd1;
          end
          COMMIT: begin
            state <= IDLE;
            if (ev_on) begin
              if (tgt_valid) begin
                note[tgt_idx] <= ev_note;
                vel[tgt_idx]  <= ev_vel;
                act[tgt_idx]  <= 1'b1;
                for (int v = 0; v < 4; v++) begin
                  if (2'(v) == tgt_idx) begin
                    rank[v] <= 2'd0;
                  end else if (rank[v] < rank[tgt_idx]) begin
                    rank[v] <= rank[v] + 2'd1;
                  end
                end
              end
            end else if (match_found) begin
              // Pitch is left in place so the NCO does not jump during release.
              vel[match_idx] <= 7'd0;
              act[match_idx] <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign note_num_0 = note[0];
  assign note_num_1 = note[1];
  assign note_num_2 = note[2];
  assign note_num_3 = note[3];
  assign note_vel_0 = vel[0];
  assign note_vel_1 = vel[1];
  assign note_vel_2 = vel[2];
  assign note_vel_3 = vel[3];
  assign active     = act;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: a stealing instance and a dropping instance
// receive the same event stream and are checked against hand-computed values.
module tb_voice_alloc;

  logic clk;
  logic rst;
  logic ce;
  logic all_off;

  voice_alloc_if bus  ();
  voice_alloc_if bus0 ();

  logic [6:0] s_num [4];
  logic [6:0] s_vel [4];
  logic [3:0] s_act;
  logic [6:0] d_num [4];
  logic [6:0] d_vel [4];
  logic [3:0] d_act;

  int checks = 0;
  int errors = 0;

  voice_alloc #(.STEAL(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .all_off(all_off), .evt(bus),
    .note_num_0(s_num[0]), .note_num_1(s_num[1]), .note_num_2(s_num[2]), .note_num_3(s_num[3]),
    .note_vel_0(s_vel[0]), .note_vel_1(s_vel[1]), .note_vel_2(s_vel[2]), .note_vel_3(s_vel[3]),
    .active(s_act)
  );

  voice_alloc #(.STEAL(1'b0)) dut_drop (
    .clk(clk), .rst(rst), .ce(ce), .all_off(all_off), .evt(bus0),
    .note_num_0(d_num[0]), .note_num_1(d_num[1]), .note_num_2(d_num[2]), .note_num_3(d_num[3]),
    .note_vel_0(d_vel[0]), .note_vel_1(d_vel[1]), .note_vel_2(d_vel[2]), .note_vel_3(d_vel[3]),
    .active(d_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic on, input logic [6:0] n, input logic [6:0] vl);
    bus.evt_valid  = v;
    bus.evt_on     = on;
    bus.evt_note   = n;
    bus.evt_vel    = vl;
    bus0.evt_valid = v;
    bus0.evt_on    = on;
    bus0.evt_note  = n;
    bus0.evt_vel   = vl;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ce      = 1'b1;
    all_off = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one event, let it be accepted, then wait out scan and commit.
  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] vl);
    int guard;
    guard = 0;
    while (!bus.evt_rdy && guard < 20) begin
      step();
      guard++;
    end
    chk("rdy_before_send", 8'(bus.evt_rdy), 8'd1);
    drive(1'b1, on, n, vl);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    repeat (5) step();
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    all_off = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 7'd0);

    // Reset values, then single note-on with latency check
    do_reset();
    chk("rst_num0", 8'(s_num[0]), 8'd0);
    chk("rst_vel0", 8'(s_vel[0]), 8'd0);
    chk("rst_active", 8'(s_act), 8'd0);
    chk("rst_rdy", 8'(bus.evt_rdy), 8'd1);
    drive(1'b1, 1'b1, 7'd60, 7'd100);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    chk("scan_rdy_low", 8'(bus.evt_rdy), 8'd0);
    repeat (4) step();
    chk("pre_commit_vel0", 8'(s_vel[0]), 8'd0);
    step();
    chk("t1_num0", 8'(s_num[0]), 8'd60);
    chk("t1_vel0", 8'(s_vel[0]), 8'd100);
    chk("t1_active", 8'(s_act), 8'b0001);
    chk("t1_rdy", 8'(bus.evt_rdy), 8'd1);

    // Fill all voices, then steal (STEAL=1) or drop (STEAL=0)
    do_reset();
    send(1'b1, 7'd60, 7'd10);
    send(1'b1, 7'd62, 7'd20);
    send(1'b1, 7'd64, 7'd30);
    send(1'b1, 7'd65, 7'd40);
    chk("t2_full_active", 8'(s_act), 8'b1111);
    send(1'b1, 7'd67, 7'd77);
    chk("t2_steal_num0", 8'(s_num[0]), 8'd67);
    chk("t2_steal_vel0", 8'(s_vel[0]), 8'd77);
    chk("t2_steal_num1", 8'(s_num[1]), 8'd62);
    chk("t2_steal_active", 8'(s_act), 8'b1111);
    chk("t2_drop_num0", 8'(d_num[0]), 8'd60);
    chk("t2_drop_vel0", 8'(d_vel[0]), 8'd10);
    chk("t2_drop_active", 8'(d_act), 8'b1111);
    send(1'b1, 7'd69, 7'd5);
    chk("t2_steal2_num1", 8'(s_num[1]), 8'd69);
    chk("t2_steal2_vel1", 8'(s_vel[1]), 8'd5);
    chk("t2_steal2_num0", 8'(s_num[0]), 8'd67);
    chk("t2_drop2_num1", 8'(d_num[1]), 8'd62);

    // Retrigger reuses the matching voice
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd60, 7'd50);
    chk("t3_vel0", 8'(s_vel[0]), 8'd50);
    chk("t3_vel1", 8'(s_vel[1]), 8'd0);
    chk("t3_active", 8'(s_act), 8'b0001);

    // Note-off, velocity-zero note-on, unmatched note-off
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b0, 7'd60, 7'd64);
    chk("t4_off_num0", 8'(s_num[0]), 8'd60);
    chk("t4_off_vel0", 8'(s_vel[0]), 8'd0);
    chk("t4_off_active", 8'(s_act), 8'b0000);
    send(1'b1, 7'd60, 7'd100);
    chk("t4_reon_vel0", 8'(s_vel[0]), 8'd100);
    send(1'b1, 7'd60, 7'd0);
    chk("t4_vel0off_vel0", 8'(s_vel[0]), 8'd0);
    chk("t4_vel0off_active", 8'(s_act), 8'b0000);
    send(1'b1, 7'd60, 7'd100);
    send(1'b0, 7'd61, 7'd0);
    chk("t4_nomatch_vel0", 8'(s_vel[0]), 8'd100);
    chk("t4_nomatch_active", 8'(s_act), 8'b0001);

    // Back-to-back events: second waits for the next IDLE
    do_reset();
    drive(1'b1, 1'b1, 7'd60, 7'd100);
    step();
    drive(1'b1, 1'b1, 7'd62, 7'd90);
    for (int i = 0; i < 5; i++) begin
      chk("t5_busy_rdy", 8'(bus.evt_rdy), 8'd0);
      step();
    end
    chk("t5_idle_rdy", 8'(bus.evt_rdy), 8'd1);
    chk("t5_first_vel0", 8'(s_vel[0]), 8'd100);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    chk("t5_second_accept", 8'(bus.evt_rdy), 8'd0);
    repeat (4) step();
    chk("t5_second_pending", 8'(s_vel[1]), 8'd0);
    step();
    chk("t5_second_num1", 8'(s_num[1]), 8'd62);
    chk("t5_second_vel1", 8'(s_vel[1]), 8'd90);

    // Clock enable stretches latency by the CE=0 cycles
    drive(1'b1, 1'b1, 7'd64, 7'd30);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    step();
    ce = 1'b0;
    repeat (3) step();
    chk("t5_ce_hold_rdy", 8'(bus.evt_rdy), 8'd0);
    ce = 1'b1;
    repeat (3) step();
    chk("t5_ce_pending", 8'(s_vel[2]), 8'd0);
    step();
    chk("t5_ce_vel2", 8'(s_vel[2]), 8'd30);
    chk("t5_ce_num2", 8'(s_num[2]), 8'd64);
    chk("t5_ce_active", 8'(s_act), 8'b0111);

    // No accept while CE=0
    ce = 1'b0;
    drive(1'b1, 1'b1, 7'd65, 7'd11);
    repeat (3) step();
    chk("t5_ce0_rdy", 8'(bus.evt_rdy), 8'd1);
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    ce = 1'b1;
    repeat (6) step();
    chk("t5_ce0_vel3", 8'(s_vel[3]), 8'd0);
    chk("t5_ce0_active", 8'(s_act), 8'b0111);

    // ALL_OFF mid-scan silences everything and discards the event
    drive(1'b1, 1'b1, 7'd66, 7'd44);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    step();
    step();
    all_off = 1'b1;
    step();
    all_off = 1'b0;
    chk("t6_alloff_active", 8'(s_act), 8'b0000);
    chk("t6_alloff_vel0", 8'(s_vel[0]), 8'd0);
    chk("t6_alloff_vel2", 8'(s_vel[2]), 8'd0);
    chk("t6_alloff_num0", 8'(s_num[0]), 8'd60);
    chk("t6_alloff_rdy", 8'(bus.evt_rdy), 8'd1);
    repeat (6) step();
    chk("t6_alloff_vel3", 8'(s_vel[3]), 8'd0);
    chk("t6_alloff_num3", 8'(s_num[3]), 8'd0);
    chk("t6_alloff_after", 8'(s_act), 8'b0000);

    // Reset mid-scan returns to reset values immediately
    send(1'b1, 7'd50, 7'd20);
    chk("t6_pre_rst_vel0", 8'(s_vel[0]), 8'd20);
    drive(1'b1, 1'b1, 7'd70, 7'd12);
    step();
    drive(1'b0, 1'b0, 7'd0, 7'd0);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_vel0", 8'(s_vel[0]), 8'd0);
    chk("t6_rst_num0", 8'(s_num[0]), 8'd0);
    chk("t6_rst_active", 8'(s_act), 8'b0000);
    chk("t6_rst_rdy", 8'(bus.evt_rdy), 8'd1);
    rst = 1'b0;
    repeat (7) step();
    chk("t6_rst_lost_active", 8'(s_act), 8'b0000);
    chk("t6_rst_lost_num0", 8'(s_num[0]), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
